// File: rtl/rab_wr_drop_responder.sv
// -----------------------------------------------------------------------------
// rab_wr_drop_responder
//
// Write-side companion to the RAB address-decision FSM. Each AW decision
// (accept or drop) is queued in AW order. The W bursts that follow are steered
// by the queue head:
//   - accepted bursts pass through to the master W port;
//   - dropped bursts are sunk locally.
// Every dropped burst produces a SLVERR-style write response. That response is
// arbitrated fairly against forwarded master B responses onto the slave B
// channel. Data and strobe buses are routed outside this block; only the
// control handshakes pass through here.
//
// Ports
//   s_axi_aclk / s_axi_aresetn   clock, asynchronous active-low reset
//   accept_i / drop_i / id_i     one-cycle decision pulse with its AW ID
//   ready_o                      room for another decision
//   s_axi_w*  / m_axi_w*         slave/master W handshake (valid, ready, last)
//   s_axi_b*  / m_axi_b*         slave/master B handshake, ID and response
// -----------------------------------------------------------------------------
module rab_wr_drop_responder #(
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned DEPTH    = 4,
  parameter logic [1:0]  ERR_RESP = 2'b10
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_aresetn,
  // decision interface
  input  logic                accept_i,
  input  logic                drop_i,
  input  logic [ID_WIDTH-1:0] id_i,
  output logic                ready_o,
  // slave W
  input  logic                s_axi_wvalid,
  input  logic                s_axi_wlast,
  output logic                s_axi_wready,
  // master W
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  // slave B
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  output logic [ID_WIDTH-1:0] s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  // master B
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  input  logic [ID_WIDTH-1:0] m_axi_bid,
  input  logic [1:0]          m_axi_bresp
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                drop;
    logic [ID_WIDTH-1:0] id;
  } ord_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_FWD  = 2'd1,
    GNT_ERR  = 2'd2
  } grant_e;

  // ---------------------------------------------------------------------------
  // Order queue: {drop, id} per decided burst, in AW order
  // ---------------------------------------------------------------------------
  ord_entry_t          ord_mem [DEPTH];
  logic [PW-1:0]       ord_wr_q, ord_rd_q;
  logic [CW-1:0]       ord_cnt_q;
  ord_entry_t          ord_head;
  logic                ord_push, ord_pop;

  // ---------------------------------------------------------------------------
  // Error queue: ids of dropped bursts still waiting for their B response
  // ---------------------------------------------------------------------------
  logic [ID_WIDTH-1:0] err_mem [DEPTH];
  logic [PW-1:0]       err_wr_q, err_rd_q;
  logic [CW-1:0]       err_cnt_q;
  logic                err_push, err_pop;

  // B arbiter state
  grant_e              grant_q;
  logic                last_err_q;

  logic [CW:0]         total_cnt;

  assign ord_head = ord_mem[ord_rd_q];
  assign ord_push = accept_i | drop_i;
  assign ord_pop  = (ord_cnt_q != '0) & s_axi_wvalid & s_axi_wready & s_axi_wlast;
  // A dropped burst moves from the order queue to the error queue on its last
  // beat, so the combined occupancy is unchanged by that transfer.
  assign err_push = ord_pop & ord_head.drop;
  assign err_pop  = (grant_q == GNT_ERR) & s_axi_bready;

  // Both queues share one budget, so neither can overflow on its own.
  assign total_cnt = {1'b0, ord_cnt_q} + {1'b0, err_cnt_q};
  assign ready_o   = total_cnt < (CW + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Queue storage
  // ---------------------------------------------------------------------------
  // NOTE: storage arrays carry no reset; validity is tracked by the reset
  // pointers and counts, so stale contents are never observed.
  always_ff @(posedge s_axi_aclk) begin
    if (ord_push) ord_mem[ord_wr_q] <= '{drop: drop_i, id: id_i};
    if (err_push) err_mem[err_wr_q] <= ord_head.id;
  end

  // ---------------------------------------------------------------------------
  // Queue pointers and counts
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      ord_wr_q  <= '0;
      ord_rd_q  <= '0;
      ord_cnt_q <= '0;
      err_wr_q  <= '0;
      err_rd_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (ord_push) ord_wr_q <= ord_wr_q + 1'b1;
      if (ord_pop)  ord_rd_q <= ord_rd_q + 1'b1;
      case ({ord_push, ord_pop})
        2'b10:   ord_cnt_q <= ord_cnt_q + 1'b1;
        2'b01:   ord_cnt_q <= ord_cnt_q - 1'b1;
        default: ord_cnt_q <= ord_cnt_q;
      endcase

      if (err_push) err_wr_q <= err_wr_q + 1'b1;
      if (err_pop)  err_rd_q <= err_rd_q + 1'b1;
      case ({err_push, err_pop})
        2'b10:   err_cnt_q <= err_cnt_q + 1'b1;
        2'b01:   err_cnt_q <= err_cnt_q - 1'b1;
        default: err_cnt_q <= err_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // W steering, zero latency from the order-queue head
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    s_axi_wready = 1'b0;
    m_axi_wvalid = 1'b0;
    if (ord_cnt_q != '0) begin
      if (ord_head.drop) begin
        s_axi_wready = 1'b1;
      end else begin
        m_axi_wvalid = s_axi_wvalid;
        s_axi_wready = m_axi_wready;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // B arbiter
  // ---------------------------------------------------------------------------
  // A grant is taken in a NONE cycle and held until the slave handshake. The
  // presented response therefore stays stable until it is accepted. When both
  // sources are waiting, last_err_q gives the turn to the other source.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      grant_q    <= GNT_NONE;
      last_err_q <= 1'b0;
    end else begin
      case (grant_q)
        GNT_NONE: begin
          if ((err_cnt_q != '0) && (!m_axi_bvalid || !last_err_q)) begin
            grant_q <= GNT_ERR;
          end else if (m_axi_bvalid) begin
            grant_q <= GNT_FWD;
          end
        end
        GNT_FWD: begin
          if (m_axi_bvalid && s_axi_bready) begin
            grant_q    <= GNT_NONE;
            last_err_q <= 1'b0;
          end
        end
        GNT_ERR: begin
          if (s_axi_bready) begin
            grant_q    <= GNT_NONE;
            last_err_q <= 1'b1;
          end
        end
        default: grant_q <= GNT_NONE;
      endcase
    end
  end

  always_comb begin
    s_axi_bvalid = 1'b0;
    s_axi_bid    = '0;
    s_axi_bresp  = 2'b00;
    m_axi_bready = 1'b0;
    case (grant_q)
      GNT_FWD: begin
        s_axi_bvalid = m_axi_bvalid;
        s_axi_bid    = m_axi_bid;
        s_axi_bresp  = m_axi_bresp;
        m_axi_bready = s_axi_bready;
      end
      GNT_ERR: begin
        s_axi_bvalid = 1'b1;
        s_axi_bid    = err_mem[err_rd_q];
        s_axi_bresp  = ERR_RESP;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Illegal decision usage
  // ---------------------------------------------------------------------------
  a_one_hot_decision : assert property (
    @(posedge s_axi_aclk) disable iff (!s_axi_aresetn) !(accept_i && drop_i));

  a_push_when_ready : assert property (
    @(posedge s_axi_aclk) disable iff (!s_axi_aresetn) (accept_i || drop_i) |-> ready_o);

endmodule
